// File: rtl/data_mem_responder.sv
// Multi-cycle data memory for the MEM stage: holds the pipeline for LATENCY cycles
// per access, then completes the read or write and pulses done.
module data_mem_responder #(
  parameter int LATENCY = 3,
  parameter int ADDR_W  = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        stall,
  output logic        done,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            state, next_state;
  logic [3:0]        cnt, next_cnt;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic              write_q;
  logic [31:0]       mem [2**ADDR_W];

  logic              req, accept, complete;
  logic [ADDR_W-1:0] eff_addr;
  logic [31:0]       eff_wdata;
  logic              eff_write;
  logic              unused_addr_bits;

  assign req = MemRead | MemWrite;
  assign unused_addr_bits = ^{Address[31:ADDR_W+2], Address[1:0]};

  // With LATENCY==1 the access completes on the acceptance edge, before the latches hold anything.
  assign eff_addr  = (state == IDLE) ? Address[ADDR_W+1:2] : addr_q;
  assign eff_wdata = (state == IDLE) ? WriteData : wdata_q;
  assign eff_write = (state == IDLE) ? MemWrite : write_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= next_state;
      cnt   <= next_cnt;
    end
  end

  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    stall      = 1'b0;
    done       = 1'b0;
    accept     = 1'b0;
    complete   = 1'b0;
    case (state)
      IDLE: begin
        stall = req & ~rst;
        if (req) begin
          accept = 1'b1;
          if (LATENCY == 1) begin
            next_state = DONE;
            complete   = 1'b1;
          end else begin
            next_state = BUSY;
            next_cnt   = 4'(LATENCY - 2);
          end
        end
      end
      BUSY: begin
        stall = 1'b1;
        if (cnt == 4'd0) begin
          next_state = DONE;
          complete   = 1'b1;
        end else begin
          next_cnt = cnt - 4'd1;
        end
      end
      DONE: begin
        done       = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q   <= '0;
      wdata_q  <= '0;
      write_q  <= 1'b0;
      ReadData <= '0;
      err      <= 1'b0;
    end else begin
      if (accept) begin
        addr_q  <= Address[ADDR_W+1:2];
        wdata_q <= WriteData;
        write_q <= MemWrite;
        err     <= err | (MemRead & MemWrite);
      end
      if (complete && !eff_write)
        ReadData <= mem[eff_addr];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2**ADDR_W; i++)
        mem[i] <= '0;
    end else if (complete && eff_write) begin
      mem[eff_addr] <= eff_wdata;
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: directed and random accesses on a LATENCY=3 and a
// LATENCY=1 instance, checked against a transaction-level memory model.
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read, mem_write, sel;
  logic [31:0] address, write_data;

  logic        rd3, wr3, rd1, wr1;
  logic [31:0] rdata3, rdata1;
  logic        stall3, stall1, done3, done1, err3, err1;
  logic [31:0] obs_rdata;
  logic        obs_stall, obs_done, obs_err;

  logic [31:0] model_mem [0:1023];
  logic [31:0] model_rdata;
  logic        model_err;
  int          compared = 0;
  int          mismatched = 0;

  always #5 clk = ~clk;

  // Only the selected instance sees requests; the other sits idle.
  assign rd3 = mem_read & ~sel;
  assign wr3 = mem_write & ~sel;
  assign rd1 = mem_read & sel;
  assign wr1 = mem_write & sel;

  assign obs_rdata = sel ? rdata1 : rdata3;
  assign obs_stall = sel ? stall1 : stall3;
  assign obs_done  = sel ? done1 : done3;
  assign obs_err   = sel ? err1 : err3;

  data_mem_responder #(.LATENCY(3), .ADDR_W(10)) dut3 (
    .clk(clk), .rst(rst), .MemRead(rd3), .MemWrite(wr3), .Address(address),
    .WriteData(write_data), .ReadData(rdata3), .stall(stall3), .done(done3), .err(err3)
  );

  data_mem_responder #(.LATENCY(1), .ADDR_W(10)) dut1 (
    .clk(clk), .rst(rst), .MemRead(rd1), .MemWrite(wr1), .Address(address),
    .WriteData(write_data), .ReadData(rdata1), .stall(stall1), .done(done1), .err(err1)
  );

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_status(input string tag, input logic exp_stall, input logic exp_done);
    check_output({tag, "/stall"}, {31'd0, obs_stall}, {31'd0, exp_stall});
    check_output({tag, "/done"}, {31'd0, obs_done}, {31'd0, exp_done});
    check_output({tag, "/rdata"}, obs_rdata, model_rdata);
    check_output({tag, "/err"}, {31'd0, obs_err}, {31'd0, model_err});
  endtask

  task automatic model_reset();
    for (int i = 0; i < 1024; i++) model_mem[i] = 32'd0;
    model_rdata = 32'd0;
    model_err   = 1'b0;
  endtask

  // One complete access: lat stalled cycles then a DONE cycle. Inputs are
  // scrambled after acceptance since the responder must work from its own copies.
  task automatic apply_stimulus(input logic rd, input logic wr, input logic [31:0] addr,
                                input logic [31:0] wdata, input int lat, input bit pre_driven);
    int idx;
    idx = int'(addr[11:2]);
    if (!pre_driven) begin
      @(negedge clk);
      mem_read = rd; mem_write = wr; address = addr; write_data = wdata;
      #1;
    end
    for (int k = 0; k < lat; k++) begin
      if (k > 0) begin
        @(negedge clk);
        address = $urandom; write_data = $urandom;
        #1;
      end
      check_status(rd ? "rd_stall" : "wr_stall", 1'b1, 1'b0);
      if (k == 0) model_err = model_err | (rd & wr);
    end
    @(negedge clk);
    #1;
    if (wr) model_mem[idx] = wdata;
    else    model_rdata = model_mem[idx];
    check_status(rd & ~wr ? "rd_done" : "wr_done", 1'b0, 1'b1);
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    mem_read = 1'b0; mem_write = 1'b0;
    #1;
    check_status("idle", 1'b0, 1'b0);
  endtask

  task automatic random_accesses(input int n, input int lat);
    logic [31:0] a;
    int op;
    for (int i = 0; i < n; i++) begin
      a = ($urandom & 32'hFFFF_F000) | {27'd0, 3'($urandom_range(0, 7)), 2'b00}
          | 32'($urandom_range(0, 3));
      op = $urandom_range(0, 9);
      if (op < 5)      apply_stimulus(1'b1, 1'b0, a, $urandom, lat, 1'b0);
      else if (op < 9) apply_stimulus(1'b0, 1'b1, a, $urandom, lat, 1'b0);
      else             apply_stimulus(1'b1, 1'b1, a, $urandom, lat, 1'b0);
      if ($urandom_range(0, 3) == 0) idle_cycle();
    end
  endtask

  task automatic reset_mid_write(input int lat);
    @(negedge clk);
    mem_read = 1'b0; mem_write = 1'b1; address = 32'h40; write_data = 32'hFFFF0000;
    #1;
    check_status("midrst_c1", 1'b1, 1'b0);
    if (lat > 1) begin
      @(negedge clk);
      #1;
      check_status("midrst_c2", 1'b1, 1'b0);
    end
    rst = 1'b1;
    #1;
    model_reset();
    check_status("midrst_rst", 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0; mem_write = 1'b0;
    #1;
    check_status("midrst_rel", 1'b0, 1'b0);
    apply_stimulus(1'b1, 1'b0, 32'h40, 32'h0, lat, 1'b0);
    check_output("midrst_read", obs_rdata, 32'h0);
  endtask

  initial begin
    sel = 1'b0;
    rst = 1'b1;
    mem_read = 1'b1; mem_write = 1'b0; address = 32'h10; write_data = 32'h0;
    model_reset();
    repeat (2) begin
      @(negedge clk);
      #1;
      check_status("reset", 1'b0, 1'b0);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    apply_stimulus(1'b1, 1'b0, 32'h10, 32'h0, 3, 1'b1);

    apply_stimulus(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 3, 1'b0);
    apply_stimulus(1'b1, 1'b0, 32'h10, 32'h0, 3, 1'b0);
    check_output("wr_rd_10", obs_rdata, 32'hDEADBEEF);
    idle_cycle();

    apply_stimulus(1'b0, 1'b1, 32'h1003, 32'h12345678, 3, 1'b0);
    apply_stimulus(1'b1, 1'b0, 32'h0, 32'h0, 3, 1'b0);
    check_output("wrap_word0", obs_rdata, 32'h12345678);
    idle_cycle();

    apply_stimulus(1'b1, 1'b0, 32'h10, 32'h0, 3, 1'b0);
    apply_stimulus(1'b1, 1'b0, 32'h0, 32'h0, 3, 1'b0);
    idle_cycle();

    apply_stimulus(1'b1, 1'b1, 32'h20, 32'hA5A5A5A5, 3, 1'b0);
    check_output("both_err", {31'd0, obs_err}, 32'd1);
    check_output("both_rdata_kept", obs_rdata, 32'h12345678);
    apply_stimulus(1'b1, 1'b0, 32'h20, 32'h0, 3, 1'b0);
    check_output("both_word", obs_rdata, 32'hA5A5A5A5);
    idle_cycle();

    random_accesses(40, 3);
    idle_cycle();
    reset_mid_write(3);
    idle_cycle();

    @(negedge clk);
    sel = 1'b1; rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0;
    #1;
    model_reset();
    check_status("reset_l1", 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_status("rel_l1", 1'b0, 1'b0);

    apply_stimulus(1'b0, 1'b1, 32'h10, 32'hCAFEF00D, 1, 1'b0);
    apply_stimulus(1'b1, 1'b0, 32'h10, 32'h0, 1, 1'b0);
    check_output("l1_wr_rd", obs_rdata, 32'hCAFEF00D);
    apply_stimulus(1'b1, 1'b0, 32'h14, 32'h0, 1, 1'b0);
    idle_cycle();
    random_accesses(40, 1);
    idle_cycle();
    reset_mid_write(1);
    idle_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Multi-cycle data-memory responder that sits on the MEM-stage side of the pipelined datapath, in place of the single-cycle data memory.
- It accepts the MEM-stage read/write request, holds the pipeline via a stall output for a configurable latency, then completes the access.
- It drives read data back to the MEM/WB path in the cycle the stall drops.
- The hazard unit ORs its stall into the pipeline-freeze logic: PC, IF/ID, ID/EX and EX/MEM are held while stall=1.

Parameters:
- LATENCY, 3, stall cycles per access; legal range 1..15.
- ADDR_W, 10, word-index width; memory depth is 2^ADDR_W 32-bit words.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  reset, asynchronous, active-high
- MemRead  input  1  read request from EX/MEM register
- MemWrite  input  1  write request from EX/MEM register
- Address  input  32  byte address (ALU result)
- WriteData  input  32  store data
- ReadData  output  32  registered load data
- stall  output  1  pipeline hold request
- done  output  1  one-cycle pulse; access completed this cycle
- err  output  1  sticky flag; MemRead and MemWrite were both seen at acceptance

Behaviour:
- Clock and reset: one clock (clk). Reset (rst) is asynchronous and active-high.
- Reset values:
  - state=IDLE, cnt=0, ReadData=0, done=0, err=0.
  - All memory words are cleared to 0.
  - stall=0 while rst is high.
- Request: req = MemRead | MemWrite.
- Word index: Address[ADDR_W+1:2]. Address[1:0] and the upper bits are ignored, so out-of-range addresses wrap.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - stall = req, combinational.
  - If req: latch Address, WriteData and op (write has priority if both are set; err is set).
  - Next state is DONE if LATENCY==1; otherwise BUSY with cnt = LATENCY-2.
  - If no req: stay in IDLE.
- BUSY:
  - stall=1.
  - If cnt==0, go to DONE; otherwise cnt decrements.
  - Inputs are ignored; the latched copies are used.
- DONE:
  - stall=0, done=1.
  - Write: the memory word is updated on the edge entering DONE.
  - Read: ReadData is loaded on the edge entering DONE and holds until the next read completes.
  - Next state is always IDLE. The still-present request in the DONE cycle is the same instruction and is not re-accepted; the pipeline advances on this edge.
- Stall length: stall is high for exactly LATENCY consecutive cycles per access. Back-to-back memory ops give the pattern LATENCY stalled cycles, 1 DONE cycle, then the next acceptance.
- Writes and reads never update ReadData from a write.
- Read after write to the same word returns the new data.
- Reset mid-access: FSM returns to IDLE, a pending write is discarded, and stall drops immediately.
- err clears only on rst.

Test Plan:
- Reset: assert rst for 2 cycles with MemRead=1 → stall=0, ReadData=0, done=0, err=0; after release, stall rises in the same cycle because MemRead is still 1.
- Write then read (LATENCY=3):
  - Write: MemWrite=1, Address=0x10, WriteData=0xDEADBEEF held → stall=1 for 3 cycles, done=1 in the 4th cycle.
  - Read: MemRead=1, Address=0x10 → after 3 stall cycles ReadData=0xDEADBEEF with done=1.
- Address wrap/alignment (ADDR_W=10):
  - Write 0x12345678 at byte address 0x1003 → it lands at word 0.
  - Read at Address=0x0 → 0x12345678.
- Back-to-back reads with req held high across two different addresses → stall pattern 1,1,1,0,1,1,1,0. done pulses exactly twice. ReadData updates only in the DONE cycles.
- Both MemRead=1 and MemWrite=1, Address=0x20, WriteData=0xA5A5A5A5 → err=1 and stays 1; the word at 0x20 becomes 0xA5A5A5A5; ReadData is unchanged.
- Reset mid-write: MemWrite to 0x40 with 0xFFFF0000, rst pulsed during cycle 2 of the stall → stall=0 immediately; a subsequent read of 0x40 returns 0x00000000. Repeat with LATENCY=1 → stall is 1 cycle only.
